// File: rtl/alu_result_buffer.sv
// alu_result_buffer: circular result buffer between the ALU and its consumer.
// Stores result, op and precomputed zero/neg flags; counts and flags overflow.
module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [1:0]               in_select,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_op,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [1:0]       op;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic          drop;

  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;
  assign count     = count_q;

  // Flags are derived once, at write time, and stored with the word.
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = in_result;
    wr_entry.op     = in_select;
    wr_entry.zero   = in_result == '0;
    wr_entry.neg    = in_result[WIDTH-1];
  end

  // Head entry presented combinationally; forced to zero while empty.
  always_comb begin
    head     = mem[rd_ptr];
    out_data = '0;
    out_op   = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (out_valid) begin
      out_data = head.result;
      out_op   = head.op;
      out_zero = head.zero;
      out_neg  = head.neg;
    end
  end

  // Storage array: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; reset wins over a same-edge push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Lost-word accounting: saturating drop counter and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed stimulus with scoreboard queue and
// a negedge monitor comparing every popped head entry.
module tb_alu_result_buffer;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] op;
    logic       z;
    logic       n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_result = '0;
  logic [1:0] in_select = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_op;
  logic       out_zero;
  logic       out_neg;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  logic       overflow;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_result_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_result(in_result),
    .in_select(in_select), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg),
    .count(count), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] op,
                      input logic z, input logic n, input bit acc);
    exp_t e;
    e.d = d; e.op = op; e.z = z; e.n = n;
    in_valid  = 1'b1;
    in_result = d;
    in_select = op;
    if (acc) q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got data %0h expected none", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({out_data, out_op, out_zero, out_neg} != e) begin
          miscompares++;
          $display("FAIL pop_head: got d=%0h op=%0d z=%0b n=%0b expected d=%0h op=%0d z=%0b n=%0b",
                   out_data, out_op, out_zero, out_neg, e.d, e.op, e.z, e.n);
        end
      end
    end
  end

  logic [7:0] sd [12] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h3C,
                          8'hC3, 8'h00, 8'h5A, 8'hA5, 8'h10, 8'hF0};
  logic       sz [12] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic       sn [12] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    // reset
    step();
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_fields", {out_data, out_op, out_zero, out_neg}, 0);

    // single zero word, zero latency to head
    send(8'h00, 2'd2, 1'b1, 1'b0, 1'b1);
    chk("one_count", count, 1);
    chk("one_valid", out_valid, 1);
    chk("one_data", out_data, 8'h00);
    chk("one_op", out_op, 2);
    chk("one_zero", out_zero, 1);
    chk("one_neg", out_neg, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("one_drained", count, 0);

    // fill, overflow, drain in order
    send(8'h81, 2'd1, 1'b0, 1'b1, 1'b1);
    send(8'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    send(8'h7F, 2'd3, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 2'd2, 1'b0, 1'b1, 1'b1);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    send(8'h10, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", out_data, 8'h81);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_out_data", out_data, 0);

    // streaming across pointer wrap, no bypass when empty
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(sd[i], 2'(i % 4), sz[i], sn[i], 1'b1);
      chk("stream_count", count, 1);
    end
    step();
    out_ready = 1'b0;
    chk("stream_empty", count, 0);
    chk("stream_no_drop", drop_cnt, 1);

    // full with push and pop same cycle: pop happens, word dropped
    send(8'hA0, 2'd0, 1'b0, 1'b1, 1'b1);
    send(8'hA1, 2'd1, 1'b0, 1'b1, 1'b1);
    send(8'hA2, 2'd2, 1'b0, 1'b1, 1'b1);
    send(8'hA3, 2'd3, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    send(8'h55, 2'd1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("pp_count", count, 3);
    chk("pp_drop_cnt", drop_cnt, 2);
    chk("pp_in_ready", in_ready, 1);

    // reset mid-stream with push and pop active
    rst = 1'b1;
    in_valid = 1'b1;
    in_result = 8'h99;
    out_ready = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_drop_cnt", drop_cnt, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_in_ready", in_ready, 1);

    // drop counter saturation
    send(8'h01, 2'd0, 1'b0, 1'b0, 1'b1);
    send(8'h02, 2'd1, 1'b0, 1'b0, 1'b1);
    send(8'h03, 2'd2, 1'b0, 1'b0, 1'b1);
    send(8'h04, 2'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      send(8'hEE, 2'd0, 1'b0, 1'b1, 1'b0);
      if (i == 9) chk("sat_drop_10", drop_cnt, 10);
    end
    chk("sat_drop_cnt", drop_cnt, 255);
    chk("sat_overflow", overflow, 1);
    chk("sat_count", count, 4);

    // bounded final drain
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) step();
    step();
    out_ready = 1'b0;
    chk("final_queue_left", q.size(), 0);
    chk("final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
